sweep_seq_ctrl: RTL and testbench

- Sequencer and configurator for the small up/down (triangle) counter datapath used across the design.
- Accepts a bounds/mode/cycle-count configuration over a valid/ready handshake, then runs, pauses and terminates the sweep.
- Reports position, direction, boundary hits and completion to a downstream consumer, e.g. a PWM or a test-pattern source.
- Contains the counter datapath as a sub-module, so one block owns both sequencing and count state.

---
 rtl/sweep_pkg.sv | 35 +++
 rtl/sweep_step_dp.sv | 93 +++++++++
 rtl/sweep_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_sweep_seq_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// sweep_pkg: shared types and reset defaults for the sweep sequencer.
// Mode and state encodings, stored-config defaults, and the mode decoder.
// The reserved mode code decodes to BOUNCE.
package sweep_pkg;

  typedef enum logic [1:0] {
    UP_WRAP   = 2'd0,
    DOWN_WRAP = 2'd1,
    BOUNCE    = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  // Dwell field width; also used when the dwell feature is compiled out.
  localparam int DWELL_W = 4;

  // Stored-config reset defaults (bounds default to the full range in the top).
  localparam mode_t             DEF_MODE  = BOUNCE;
  localparam logic [DWELL_W-1:0] DEF_DWELL = '0;

  // Map the raw 2-bit mode field; code 3 is reserved and stored as BOUNCE.
  function automatic mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd0:    return UP_WRAP;
      2'd1:    return DOWN_WRAP;
      default: return BOUNCE;
    endcase
  endfunction

endpackage

// File: rtl/sweep_step_dp.sv
// sweep_step_dp: count/dir registers with next-value, wrap and terminal decode.
// Latency: load/step take effect at the next clk edge; wrap/at_terminal are combinational.
// Backpressure: none; the sequencer controls stepping through load/step.
module sweep_step_dp
  import sweep_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  mode_t            mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_count,
  input  logic             load_dir,
  input  logic             step,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             wrap,
  output logic             at_terminal
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] nxt_count;
  logic             nxt_dir;

  // Next count/dir for one step; lo==hi in BOUNCE holds the count so it never leaves range.
  always_comb begin
    nxt_count = count;
    nxt_dir   = dir;
    case (mode)
      UP_WRAP:   nxt_count = (count == hi) ? lo : count + ONE;
      DOWN_WRAP: nxt_count = (count == lo) ? hi : count - ONE;
      default: begin
        if (lo == hi) begin
          nxt_count = count;
        end else if (dir) begin
          if (count == hi) begin
            nxt_count = count - ONE;
            nxt_dir   = 1'b0;
          end else begin
            nxt_count = count + ONE;
          end
        end else begin
          if (count == lo) begin
            nxt_count = count + ONE;
            nxt_dir   = 1'b1;
          end else begin
            nxt_count = count - ONE;
          end
        end
      end
    endcase
  end

  // Boundary and period-end decode from the registered count/dir.
  // With lo==hi every BOUNCE position counts as the terminal value.
  always_comb begin
    wrap        = 1'b0;
    at_terminal = 1'b0;
    case (mode)
      UP_WRAP: begin
        wrap        = (count == hi);
        at_terminal = (count == hi);
      end
      DOWN_WRAP: begin
        wrap        = (count == lo);
        at_terminal = (count == lo);
      end
      default: begin
        wrap        = dir ? (count == hi) : (count == lo);
        at_terminal = (count == lo) && (!dir || (lo == hi));
      end
    endcase
  end

  // Count/dir registers: load has priority over step.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      dir   <= 1'b1;
    end else if (load) begin
      count <= load_count;
      dir   <= load_dir;
    end else if (step) begin
      count <= nxt_count;
      dir   <= nxt_dir;
    end
  end

endmodule

// File: rtl/sweep_seq_ctrl.sv
// sweep_seq_ctrl: configures and sequences the triangle/wrap counter (optional macro SWEEP_DWELL_EN).
// Latency: cfg/start act at the next edge; count starts at the initial value the edge after start.
// Backpressure: cfg_ready only in IDLE; cfg offered elsewhere is dropped, pause freezes the sweep.
module sweep_seq_ctrl
  import sweep_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int CYC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_lo,
  input  logic [WIDTH-1:0] cfg_hi,
  input  logic [1:0]       cfg_mode,
  input  logic [CYC_W-1:0] cfg_cycles,
`ifdef SWEEP_DWELL_EN
  input  logic [3:0]       cfg_dwell,
`endif
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             busy,
  output logic             wrap,
  output logic             done
);

  localparam logic [WIDTH-1:0] DEF_LO  = '0;
  localparam logic [WIDTH-1:0] DEF_HI  = '1;
  localparam logic [CYC_W-1:0] REM_ONE = CYC_W'(1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   lo_q, hi_q;
  mode_t              mode_q;
  logic [CYC_W-1:0]   cycles_q, rem_q;
  logic [DWELL_W-1:0] dwell_q, dwell_cnt_q;

  logic [DWELL_W-1:0] in_dwell;
  logic               cfg_acc;
  logic [WIDTH-1:0]   eff_lo, eff_hi;
  mode_t              eff_mode;
  logic [CYC_W-1:0]   eff_cycles;
  logic [DWELL_W-1:0] eff_dwell;
  logic [WIDTH-1:0]   load_count;
  logic               load_dir;
  logic               load, step, dec_rem, dwell_reload, dwell_dec;
  logic               at_terminal;

`ifdef SWEEP_DWELL_EN
  assign in_dwell = cfg_dwell;
`else
  assign in_dwell = '0;
`endif

  // Effective config: a same-cycle handshake overrides the stored values.
  assign cfg_acc    = (state == IDLE) && cfg_valid;
  assign eff_lo     = cfg_acc ? ((cfg_lo > cfg_hi) ? cfg_hi : cfg_lo) : lo_q;
  assign eff_hi     = cfg_acc ? ((cfg_lo > cfg_hi) ? cfg_lo : cfg_hi) : hi_q;
  assign eff_mode   = cfg_acc ? decode_mode(cfg_mode) : mode_q;
  assign eff_cycles = cfg_acc ? cfg_cycles : cycles_q;
  assign eff_dwell  = cfg_acc ? in_dwell : dwell_q;
  assign load_count = (eff_mode == DOWN_WRAP) ? eff_hi : eff_lo;
  assign load_dir   = (eff_mode != DOWN_WRAP);

  sweep_step_dp #(.WIDTH(WIDTH)) u_dp (
    .clk         (clk),
    .rst         (rst),
    .lo          (lo_q),
    .hi          (hi_q),
    .mode        (mode_q),
    .load        (load),
    .load_count  (load_count),
    .load_dir    (load_dir),
    .step        (step),
    .count       (count),
    .dir         (dir),
    .wrap        (wrap),
    .at_terminal (at_terminal)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, datapath enables and status outputs.
  // Final period: at the terminal value with one period left, finish without stepping.
  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    step         = 1'b0;
    dec_rem      = 1'b0;
    dwell_reload = 1'b0;
    dwell_dec    = 1'b0;
    cfg_ready    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (start) begin
          load         = 1'b1;
          dwell_reload = 1'b1;
          state_nxt    = pause ? HOLD : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (pause) begin
          state_nxt = HOLD;
        end else if (dwell_cnt_q != '0) begin
          dwell_dec = 1'b1;
        end else if (at_terminal && (cycles_q != '0) && (rem_q == REM_ONE)) begin
          state_nxt = DONE;
        end else begin
          step         = 1'b1;
          dwell_reload = 1'b1;
          dec_rem      = at_terminal && (cycles_q != '0);
        end
      end
      HOLD: begin
        busy = 1'b1;
        if (abort)       state_nxt = IDLE;
        else if (!pause) state_nxt = RUN;
      end
      default: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // Stored configuration, latched on an accepted handshake in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q     <= DEF_LO;
      hi_q     <= DEF_HI;
      mode_q   <= DEF_MODE;
      cycles_q <= '0;
      dwell_q  <= DEF_DWELL;
    end else if (cfg_acc) begin
      lo_q     <= eff_lo;
      hi_q     <= eff_hi;
      mode_q   <= eff_mode;
      cycles_q <= eff_cycles;
      dwell_q  <= eff_dwell;
    end
  end

  // Remaining-period and dwell counters; both hold while in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q       <= '0;
      dwell_cnt_q <= '0;
    end else begin
      if (load)         rem_q <= eff_cycles;
      else if (dec_rem) rem_q <= rem_q - REM_ONE;
      if (dwell_reload)   dwell_cnt_q <= eff_dwell;
      else if (dwell_dec) dwell_cnt_q <= dwell_cnt_q - DWELL_W'(1);
    end
  end

endmodule

// File: tb/tb_sweep_seq_ctrl.sv
// Directed bench for sweep_seq_ctrl: reset, free-run triangle, bounded sweeps,
// pause/abort, config gating, mid-sweep reset, lo==hi, and optional dwell.
module tb_sweep_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [2:0] cfg_lo = '0;
  logic [2:0] cfg_hi = '0;
  logic [1:0] cfg_mode = '0;
  logic [7:0] cfg_cycles = '0;
`ifdef SWEEP_DWELL_EN
  logic [3:0] cfg_dwell = '0;
`endif
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] count;
  logic       dir, busy, wrap, done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sweep_seq_ctrl #(.WIDTH(3), .CYC_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_lo     (cfg_lo),
    .cfg_hi     (cfg_hi),
    .cfg_mode   (cfg_mode),
    .cfg_cycles (cfg_cycles),
`ifdef SWEEP_DWELL_EN
    .cfg_dwell  (cfg_dwell),
`endif
    .start      (start),
    .pause      (pause),
    .abort      (abort),
    .count      (count),
    .dir        (dir),
    .busy       (busy),
    .wrap       (wrap),
    .done       (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer_cfg(input logic [2:0] lo, input logic [2:0] hi,
                           input logic [1:0] mode, input logic [7:0] cyc);
    cfg_valid  = 1'b1;
    cfg_lo     = lo;
    cfg_hi     = hi;
    cfg_mode   = mode;
    cfg_cycles = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({count, dir, busy, wrap, done, cfg_ready} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state got cnt=%0d dir=%b busy=%b wrap=%b done=%b rdy=%b want 0 1 0 0 0 1",
               count, dir, busy, wrap, done, cfg_ready);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({count, busy, cfg_ready} !== {3'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_release got cnt=%0d busy=%b rdy=%b want 0 0 1", count, busy, cfg_ready);
    end
  endtask

  task automatic test_free_run();
    int m;
    logic [2:0] ec;
    logic ed, ew;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      m  = k % 14;
      ec = (m <= 7) ? 3'(m) : 3'(14 - m);
      ed = (m >= 1 && m <= 7) || (m == 0 && k == 0);
      ew = (ec == 3'd7) || (ec == 3'd0 && k != 0);
      n_cmp++;
      if ({count, dir, wrap, busy, done} !== {ec, ed, ew, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL free_run k=%0d got cnt=%0d dir=%b wrap=%b busy=%b done=%b want %0d %b %b 1 0",
                 k, count, dir, wrap, busy, done, ec, ed, ew);
      end
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL free_run_abort got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_bounce_once();
    int seq [7] = '{2, 3, 4, 5, 4, 3, 2};
    logic dseq [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    offer_cfg(3'd2, 3'd5, 2'd2, 8'd1);
    start = 1'b1;
    tick();
    cfg_valid = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      n_cmp++;
      if ({count, dir, busy, done} !== {3'(seq[k]), dseq[k], 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL bounce_once k=%0d got cnt=%0d dir=%b busy=%b done=%b want %0d %b 1 0",
                 k, count, dir, busy, done, seq[k], dseq[k]);
      end
      tick();
    end
    n_cmp++;
    if ({done, busy, count} !== {1'b1, 1'b0, 3'd2}) begin
      n_err++;
      $display("FAIL bounce_done got done=%b busy=%b cnt=%0d want 1 0 2", done, busy, count);
    end
    tick();
    n_cmp++;
    if ({done, busy, count, cfg_ready} !== {1'b0, 1'b0, 3'd2, 1'b1}) begin
      n_err++;
      $display("FAIL bounce_idle got done=%b busy=%b cnt=%0d rdy=%b want 0 0 2 1",
               done, busy, count, cfg_ready);
    end
  endtask

  task automatic test_swapped_down();
    int seq [8] = '{5, 4, 3, 2, 5, 4, 3, 2};
    offer_cfg(3'd5, 3'd2, 2'd1, 8'd2);
    tick();
    cfg_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if ({count, dir, done} !== {3'(seq[k]), 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL swapped_down k=%0d got cnt=%0d dir=%b done=%b want %0d 0 0",
                 k, count, dir, done, seq[k]);
      end
      tick();
    end
    n_cmp++;
    if ({done, count} !== {1'b1, 3'd2}) begin
      n_err++;
      $display("FAIL swapped_done got done=%b cnt=%0d want 1 2", done, count);
    end
    tick();
    n_cmp++;
    if ({done, busy, count} !== {1'b0, 1'b0, 3'd2}) begin
      n_err++;
      $display("FAIL swapped_hold got done=%b busy=%b cnt=%0d want 0 0 2", done, busy, count);
    end
  endtask

  task automatic test_pause_abort();
    int pre [3]  = '{0, 1, 2};
    int post [4] = '{2, 3, 0, 1};
    offer_cfg(3'd0, 3'd3, 2'd0, 8'd0);
    start = 1'b1;
    tick();
    cfg_valid = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (count !== 3'(pre[k])) begin
        n_err++;
        $display("FAIL pause_pre k=%0d got cnt=%0d want %0d", k, count, pre[k]);
      end
      if (k < 2) tick();
    end
    pause = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if ({count, busy, done} !== {3'd2, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL pause_hold k=%0d got cnt=%0d busy=%b done=%b want 2 1 0", k, count, busy, done);
      end
    end
    pause = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if ({count, wrap} !== {3'(post[k]), post[k] == 3}) begin
        n_err++;
        $display("FAIL pause_resume k=%0d got cnt=%0d wrap=%b want %0d %b",
                 k, count, wrap, post[k], post[k] == 3);
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if ({count, busy, done} !== {3'd1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL abort got cnt=%0d busy=%b done=%b want 1 0 0", count, busy, done);
    end
    tick();
    n_cmp++;
    if ({count, done, cfg_ready} !== {3'd1, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL abort_after got cnt=%0d done=%b rdy=%b want 1 0 1", count, done, cfg_ready);
    end
  endtask

  task automatic test_cfg_in_run_and_reset();
    int seq [7] = '{1, 2, 3, 4, 5, 6, 5};
    offer_cfg(3'd1, 3'd6, 2'd2, 8'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    offer_cfg(3'd0, 3'd1, 2'd0, 8'd5);
    n_cmp++;
    if (cfg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL cfg_ready_run got %b want 0", cfg_ready);
    end
    for (int k = 0; k < 7; k++) begin
      if (k == 5) cfg_valid = 1'b0;
      n_cmp++;
      if (count !== 3'(seq[k])) begin
        n_err++;
        $display("FAIL cfg_ignored k=%0d got cnt=%0d want %0d", k, count, seq[k]);
      end
      if (k < 6) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({count, dir, busy, wrap, cfg_ready} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL mid_reset got cnt=%0d dir=%b busy=%b wrap=%b rdy=%b want 0 1 0 0 1",
               count, dir, busy, wrap, cfg_ready);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (count !== ((k <= 7) ? 3'(k) : 3'(14 - k))) begin
        n_err++;
        $display("FAIL default_cfg k=%0d got cnt=%0d want %0d", k, count, (k <= 7) ? k : 14 - k);
      end
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_lo_eq_hi();
    offer_cfg(3'd4, 3'd4, 2'd2, 8'd3);
    start = 1'b1;
    tick();
    cfg_valid = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({count, busy, done, wrap} !== {3'd4, 1'b1, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL lo_eq_hi k=%0d got cnt=%0d busy=%b done=%b wrap=%b want 4 1 0 1",
                 k, count, busy, done, wrap);
      end
      tick();
    end
    n_cmp++;
    if ({done, count} !== {1'b1, 3'd4}) begin
      n_err++;
      $display("FAIL lo_eq_hi_done got done=%b cnt=%0d want 1 4", done, count);
    end
    tick();
  endtask

  task automatic test_start_pause();
    int seq [6] = '{6, 6, 6, 5, 4, 3};
    logic bz [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    offer_cfg(3'd3, 3'd6, 2'd1, 8'd1);
    start = 1'b1;
    pause = 1'b1;
    tick();
    cfg_valid = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) pause = 1'b0;
      n_cmp++;
      if ({count, busy, done, dir} !== {3'(seq[k]), bz[k], 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL start_pause k=%0d got cnt=%0d busy=%b done=%b dir=%b want %0d 1 0 0",
                 k, count, busy, done, dir, seq[k]);
      end
      tick();
    end
    n_cmp++;
    if ({done, busy, count} !== {1'b1, 1'b0, 3'd3}) begin
      n_err++;
      $display("FAIL start_pause_done got done=%b busy=%b cnt=%0d want 1 0 3", done, busy, count);
    end
    tick();
  endtask

`ifdef SWEEP_DWELL_EN
  task automatic test_dwell();
    int seq [5] = '{0, 1, 2, 1, 0};
    offer_cfg(3'd0, 3'd2, 2'd2, 8'd1);
    cfg_dwell = 4'd2;
    start = 1'b1;
    tick();
    cfg_valid = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      n_cmp++;
      if ({count, wrap, done} !== {3'(seq[k / 3]), (k / 3 == 2) || (k / 3 == 4), 1'b0}) begin
        n_err++;
        $display("FAIL dwell k=%0d got cnt=%0d wrap=%b done=%b want %0d %b 0",
                 k, count, wrap, done, seq[k / 3], (k / 3 == 2) || (k / 3 == 4));
      end
      tick();
    end
    n_cmp++;
    if ({done, count} !== {1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL dwell_done got done=%b cnt=%0d want 1 0", done, count);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_bounce_once();
    test_swapped_down();
    test_pause_abort();
    test_cfg_in_run_and_reset();
    test_lo_eq_hi();
    test_start_pause();
`ifdef SWEEP_DWELL_EN
    test_dwell();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
